tdpram_port_arb: RTL and testbench

TDPRAM_PORT_ARB -- requirements
Module: tdpram_port_arb

---
 rtl/tdpram_port_arb.sv | 164 ++++++++++++++++
 tb/tb_tdpram_port_arb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdpram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tdpram_port_arb
// Description : Two-requester round-robin front end for one RAM port, with an
//               optional post-reset zero-fill and per-read return routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tdpram_port_arb #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_parity_err,
    output logic                  init_done,
    output logic                  err_sticky
);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;
    localparam logic [0:0] c_ST_RESET = (INIT_CLEAR != 0) ? c_ST_CLEAR : c_ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] c_CLR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] c_CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic                    r_last_grant;
    logic                    r_err;
    logic [READ_LATENCY-1:0] r_ret_vld;
    logic [READ_LATENCY-1:0] r_ret_id;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_rd_acc;
    logic                    w_ret_vld;
    logic                    w_ret_id;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: CLEAR runs once through the whole address space
    always_comb begin
        w_state_next = r_state;
        if (r_state == c_ST_CLEAR && r_clr_cnt == c_CLR_LAST) begin
            w_state_next = c_ST_RUN;
        end
    end

    // Grant is valid-qualified, so a grant is always an acceptance
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == c_ST_RUN) begin
            if (m0_valid && m1_valid) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end else begin
                w_gnt0 = m0_valid;
                w_gnt1 = m1_valid;
            end
        end
    end

    assign w_rd_acc  = (w_gnt0 && !m0_we) || (w_gnt1 && !m1_we);
    assign w_ret_vld = r_ret_vld[READ_LATENCY-1];
    assign w_ret_id  = r_ret_id[READ_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt    <= '0;
            r_last_grant <= 1'b1;
            r_err        <= 1'b0;
            r_ret_vld    <= '0;
            r_ret_id     <= '0;
        end else begin
            if (r_state == c_ST_CLEAR && r_clr_cnt != c_CLR_LAST) begin
                r_clr_cnt <= r_clr_cnt + c_CNT_ONE;
            end
            if (w_gnt0) begin
                r_last_grant <= 1'b0;
            end else if (w_gnt1) begin
                r_last_grant <= 1'b1;
            end
            if (w_ret_vld && ram_parity_err) begin
                r_err <= 1'b1;
            end
            r_ret_vld[0] <= w_rd_acc;
            r_ret_id[0]  <= w_gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_ret_vld[i] <= r_ret_vld[i-1];
                r_ret_id[i]  <= r_ret_id[i-1];
            end
        end
    end

    // Outputs are forced low for as long as rst is held
    always_comb begin
        m0_ready   = 1'b0;
        m1_ready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        init_done  = 1'b0;
        err_sticky = 1'b0;
        if (!rst) begin
            init_done  = (r_state == c_ST_RUN);
            err_sticky = r_err;
            m0_ready   = w_gnt0;
            m1_ready   = w_gnt1;
            m0_rvalid  = w_ret_vld && !w_ret_id;
            m1_rvalid  = w_ret_vld && w_ret_id;
            if (r_state == c_ST_CLEAR) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_clr_cnt;
            end else if (w_gnt0) begin
                ram_en   = 1'b1;
                ram_we   = m0_we;
                ram_addr = m0_addr;
                ram_din  = m0_wdata;
            end else if (w_gnt1) begin
                ram_en   = 1'b1;
                ram_we   = m1_we;
                ram_addr = m1_addr;
                ram_din  = m1_wdata;
            end
        end
    end

    assign m0_rdata = ram_dout;
    assign m1_rdata = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_tdpram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdpram_port_arb
// Description : Self-checking bench for tdpram_port_arb with a RAM model and a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdpram_port_arb;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int RL    = 3;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_valid, m0_ready, m0_we, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_ready, m1_we, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          ram_en, ram_we, ram_parity_err, init_done, err_sticky;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic          par_inject;

    tdpram_port_arb #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL),
        .INIT_CLEAR  (1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .m0_valid      (m0_valid),
        .m0_ready      (m0_ready),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_rvalid     (m0_rvalid),
        .m0_rdata      (m0_rdata),
        .m1_valid      (m1_valid),
        .m1_ready      (m1_ready),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_rvalid     (m1_rvalid),
        .m1_rdata      (m1_rdata),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .ram_parity_err(ram_parity_err),
        .init_done     (init_done),
        .err_sticky    (err_sticky)
    );

    // Read-first RAM with RL cycles of output latency; parity flag travels with the data
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] dpipe   [RL];
    logic          ppipe   [RL];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_din;
        dpipe[0] <= ram_mem[ram_addr];
        ppipe[0] <= ram_en && !ram_we && par_inject;
        for (int i = 1; i < RL; i++) begin
            dpipe[i] <= dpipe[i-1];
            ppipe[i] <= ppipe[i-1];
        end
    end
    assign ram_dout       = dpipe[RL-1];
    assign ram_parity_err = ppipe[RL-1];

    // Reference model state
    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
        logic          perr;
    } ret_t;
    ret_t          rq[$];
    logic [DW-1:0] mdl_mem [DEPTH];
    logic          mdl_last;
    logic          mdl_err;
    int            mdl_gnt;
    int            cyc;
    int            total = 0;
    int            bad   = 0;

    typedef struct {
        logic          v0;
        logic          we0;
        logic [AW-1:0] a0;
        logic          v1;
        logic          we1;
        logic [AW-1:0] a1;
        logic          e0;
        logic          e1;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        mdl_last = 1'b1;
        mdl_err  = 1'b0;
        mdl_gnt  = -1;
        cyc      = 0;
        rq.delete();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    endtask

    task automatic check_reset_outs(input string nm);
        chk(nm, {m0_ready, m1_ready, m0_rvalid, m1_rvalid, ram_en, ram_we, init_done, err_sticky}, 0);
        chk({nm, "_addr_din"}, {ram_addr, ram_din}, 0);
    endtask

    // n consecutive zero-fill cycles starting at address 0
    task automatic check_clear(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("clr_en_we", {ram_en, ram_we}, 2'b11);
            chk("clr_addr", ram_addr, k);
            chk("clr_din", ram_din, 0);
            chk("clr_quiet", {init_done, m0_ready, m1_ready, m0_rvalid, m1_rvalid}, 0);
            advance();
        end
    endtask

    // Drive one RUN cycle and compare every output against the model
    task automatic apply_check(input logic v0, input logic we0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic v1, input logic we1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic perr);
        logic          e_rv0, e_rv1, e_perr;
        logic [DW-1:0] e_rd;
        ret_t          r;
        m0_valid = v0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_valid = v1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        par_inject = perr;
        #2;
        if (v0 && v1)  mdl_gnt = mdl_last ? 0 : 1;
        else if (v0)   mdl_gnt = 0;
        else if (v1)   mdl_gnt = 1;
        else           mdl_gnt = -1;
        chk("init_done", init_done, 1);
        chk("ready", {m0_ready, m1_ready}, {mdl_gnt == 0, mdl_gnt == 1});
        chk("ram_en", ram_en, mdl_gnt >= 0);
        if (mdl_gnt == 0) begin
            chk("ram_cmd0", {ram_we, ram_addr}, {we0, a0});
            if (we0) chk("ram_din0", ram_din, d0);
        end else if (mdl_gnt == 1) begin
            chk("ram_cmd1", {ram_we, ram_addr}, {we1, a1});
            if (we1) chk("ram_din1", ram_din, d1);
        end else begin
            chk("ram_we_idle", ram_we, 0);
        end
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = '0; e_perr = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.id) e_rv1 = 1'b1; else e_rv0 = 1'b1;
            e_rd   = r.data;
            e_perr = r.perr;
        end
        chk("rvalid", {m0_rvalid, m1_rvalid}, {e_rv0, e_rv1});
        if (e_rv0) chk("m0_rdata", m0_rdata, e_rd);
        if (e_rv1) chk("m1_rdata", m1_rdata, e_rd);
        chk("err_sticky", err_sticky, mdl_err);
        mdl_err = mdl_err | e_perr;
        if (mdl_gnt == 0) begin
            mdl_last = 1'b0;
            if (we0) mdl_mem[a0] = d0;
            else     rq.push_back('{cyc + RL, 1'b0, mdl_mem[a0], perr});
        end else if (mdl_gnt == 1) begin
            mdl_last = 1'b1;
            if (we1) mdl_mem[a1] = d1;
            else     rq.push_back('{cyc + RL, 1'b1, mdl_mem[a1], perr});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply_check(0, 0, '0, '0, 0, 0, '0, '0, 0);
            advance();
        end
    endtask

    logic          p0, pw0, p1, pw1;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    int            t_rd;

    initial begin
        rst = 1'b1;
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        par_inject = 1'b0;
        model_reset();
        advance();
        advance();
        #2;
        check_reset_outs("reset_outs");

        m0_valid = 1'b0;
        m1_valid = 1'b0;
        rst = 1'b0;
        check_clear(DEPTH);
        model_reset();

        // Arbitration vectors; payload data is derived from the address so pending commands stay stable
        tbl[0]  = '{1, 1, 4'd1, 1, 1, 4'd2, 1, 0};
        tbl[1]  = '{1, 0, 4'd1, 1, 1, 4'd2, 0, 1};
        tbl[2]  = '{1, 0, 4'd1, 1, 0, 4'd2, 1, 0};
        tbl[3]  = '{1, 1, 4'd4, 1, 0, 4'd2, 0, 1};
        tbl[4]  = '{1, 1, 4'd4, 0, 0, 4'd0, 1, 0};
        tbl[5]  = '{0, 0, 4'd0, 0, 0, 4'd0, 0, 0};
        tbl[6]  = '{0, 0, 4'd0, 1, 1, 4'd5, 0, 1};
        tbl[7]  = '{1, 1, 4'd6, 1, 0, 4'd5, 1, 0};
        tbl[8]  = '{0, 0, 4'd0, 1, 0, 4'd5, 0, 1};
        tbl[9]  = '{1, 0, 4'd4, 1, 0, 4'd6, 1, 0};
        tbl[10] = '{1, 0, 4'd5, 1, 0, 4'd6, 0, 1};
        tbl[11] = '{1, 0, 4'd5, 0, 0, 4'd0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            apply_check(tbl[i].v0, tbl[i].we0, tbl[i].a0, 32'hA000_0000 | 32'(tbl[i].a0),
                        tbl[i].v1, tbl[i].we1, tbl[i].a1, 32'hB000_0000 | 32'(tbl[i].a1), 0);
            chk($sformatf("tbl%0d_ready", i), {m0_ready, m1_ready}, {tbl[i].e0, tbl[i].e1});
            advance();
        end
        idle(4);

        // Latency-3 return routed to m1 only
        apply_check(1, 1, 4'd3, 32'hA5A5_A5A5, 0, 0, '0, '0, 0);
        advance();
        t_rd = cyc;
        apply_check(0, 0, '0, '0, 1, 0, 4'd3, '0, 0);
        advance();
        for (int k = 1; k <= RL; k++) begin
            apply_check(0, 0, '0, '0, 0, 0, '0, '0, 0);
            chk("lat3_m1_rvalid", m1_rvalid, (cyc == t_rd + RL));
            chk("lat3_m0_rvalid", m0_rvalid, 0);
            if (k == RL) chk("lat3_rdata", m1_rdata, 32'hA5A5_A5A5);
            advance();
        end

        // Write by m0 then read of the same address by m1
        apply_check(1, 1, 4'd5, 32'h1234_5678, 0, 0, '0, '0, 0);
        advance();
        apply_check(0, 0, '0, '0, 1, 0, 4'd5, '0, 0);
        advance();
        idle(RL - 1);
        apply_check(0, 0, '0, '0, 0, 0, '0, '0, 0);
        chk("raw_rvalid", m1_rvalid, 1);
        chk("raw_rdata", m1_rdata, 32'h1234_5678);
        advance();

        // Parity error on a return sets the sticky flag, which then holds
        apply_check(1, 0, 4'd5, '0, 0, 0, '0, '0, 1);
        advance();
        idle(RL + 100);
        #1;
        chk("err_held", err_sticky, 1);

        // Read in flight when reset hits: no return may surface
        apply_check(0, 0, '0, '0, 1, 0, 4'd3, '0, 0);
        advance();
        m1_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outs("rst_run");
        for (int k = 0; k < RL; k++) begin
            advance();
            #1;
            check_reset_outs("rst_hold");
        end
        rst = 1'b0;
        check_clear(7);
        chk("clr_at7", ram_addr, 7);
        rst = 1'b1;
        #1;
        check_reset_outs("rst_clear");
        advance();
        rst = 1'b0;
        check_clear(DEPTH);
        model_reset();

        // Randomized traffic; each requester holds its command until accepted
        p0 = 1'b0; p1 = 1'b0;
        pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
                pa0 = AW'($urandom_range(0, DEPTH - 1)); pd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
                pa1 = AW'($urandom_range(0, DEPTH - 1)); pd1 = $urandom;
            end
            apply_check(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, ($urandom_range(0, 31) == 0));
            if (mdl_gnt == 0) p0 = 1'b0;
            if (mdl_gnt == 1) p1 = 1'b0;
            advance();
        end
        idle(RL + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
